// File: rtl/sfm_stream_addrgen.sv
// Streamer address generator: latches a descriptor on start and emits one address per beat.
// Optional two-dimensional addressing is enabled by defining SFM_ADDRGEN_D1_EN.
module sfm_stream_addrgen #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  req_start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  tot_len_i,
    input  logic [LEN_WIDTH-1:0]  d0_len_i,
    input  logic [ADDR_WIDTH-1:0] d0_stride_i,
    input  logic [ADDR_WIDTH-1:0] d1_stride_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic                  ready_start_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] d0_stride_q, d0_stride_d;
    logic [LEN_WIDTH-1:0]  tot_len_q, tot_len_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  start, beat, last_beat;

`ifdef SFM_ADDRGEN_D1_EN
    logic [LEN_WIDTH-1:0]  d0_len_q, d0_len_d;
    logic [LEN_WIDTH-1:0]  d0_cnt_q, d0_cnt_d;
    logic [ADDR_WIDTH-1:0] d1_stride_q, d1_stride_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
`else
    logic unused_d1;
    assign unused_d1 = ^{d0_len_i, d1_stride_i};
`endif

    assign start     = (state_q == StIdle) & req_start_i;
    assign beat      = (state_q == StRun) & addr_ready_i;
    assign last_beat = beat & (beat_cnt_q == tot_len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (req_start_i) state_d = (tot_len_i == '0) ? StDone : StRun;
                StRun:  if (last_beat) state_d = StDone;
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        addr_o        = addr_q;
        addr_valid_o  = (state_q == StRun);
        ready_start_o = (state_q == StIdle);
        busy_o        = (state_q == StRun) | (state_q == StDone);
        done_o        = (state_q == StDone);
    end

    always_comb begin
        addr_d      = addr_q;
        d0_stride_d = d0_stride_q;
        tot_len_d   = tot_len_q;
        beat_cnt_d  = beat_cnt_q;
`ifdef SFM_ADDRGEN_D1_EN
        d0_len_d    = d0_len_q;
        d0_cnt_d    = d0_cnt_q;
        d1_stride_d = d1_stride_q;
        line_base_d = line_base_q;
`endif
        if (start) begin
            addr_d      = base_addr_i;
            d0_stride_d = d0_stride_i;
            tot_len_d   = tot_len_i;
            beat_cnt_d  = '0;
`ifdef SFM_ADDRGEN_D1_EN
            d0_len_d    = d0_len_i;
            d0_cnt_d    = '0;
            d1_stride_d = d1_stride_i;
            line_base_d = base_addr_i;
`endif
        end else if (beat && !last_beat) begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
`ifdef SFM_ADDRGEN_D1_EN
            if (d0_len_q != '0 && d0_cnt_q == d0_len_q - LEN_WIDTH'(1)) begin
                d0_cnt_d    = '0;
                line_base_d = line_base_q + d1_stride_q;
                addr_d      = line_base_q + d1_stride_q;
            end else begin
                d0_cnt_d = d0_cnt_q + LEN_WIDTH'(1);
                addr_d   = addr_q + d0_stride_q;
            end
`else
            addr_d = addr_q + d0_stride_q;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            d0_stride_q <= '0;
            tot_len_q   <= '0;
            beat_cnt_q  <= '0;
`ifdef SFM_ADDRGEN_D1_EN
            d0_len_q    <= '0;
            d0_cnt_q    <= '0;
            d1_stride_q <= '0;
            line_base_q <= '0;
`endif
        end else if (clear_i) begin
            addr_q      <= '0;
            d0_stride_q <= '0;
            tot_len_q   <= '0;
            beat_cnt_q  <= '0;
`ifdef SFM_ADDRGEN_D1_EN
            d0_len_q    <= '0;
            d0_cnt_q    <= '0;
            d1_stride_q <= '0;
            line_base_q <= '0;
`endif
        end else begin
            addr_q      <= addr_d;
            d0_stride_q <= d0_stride_d;
            tot_len_q   <= tot_len_d;
            beat_cnt_q  <= beat_cnt_d;
`ifdef SFM_ADDRGEN_D1_EN
            d0_len_q    <= d0_len_d;
            d0_cnt_q    <= d0_cnt_d;
            d1_stride_q <= d1_stride_d;
            line_base_q <= line_base_d;
`endif
        end
    end

endmodule

// File: tb/tb_sfm_stream_addrgen.sv
// Directed bench for sfm_stream_addrgen; expectations follow SFM_ADDRGEN_D1_EN when defined.
module tb_sfm_stream_addrgen;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        req_start;
    logic [31:0] base_addr;
    logic [15:0] tot_len;
    logic [15:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_stride;
    logic [31:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        ready_start;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    sfm_stream_addrgen #(
        .ADDR_WIDTH(32),
        .LEN_WIDTH (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .req_start_i  (req_start),
        .base_addr_i  (base_addr),
        .tot_len_i    (tot_len),
        .d0_len_i     (d0_len),
        .d0_stride_i  (d0_stride),
        .d1_stride_i  (d1_stride),
        .addr_o       (addr),
        .addr_valid_o (addr_valid),
        .addr_ready_i (addr_ready),
        .ready_start_o(ready_start),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse a start, then scramble the live descriptor to prove it was latched.
    task automatic start(input logic [31:0] b, input logic [15:0] t, input logic [15:0] l0,
                         input logic [31:0] s0, input logic [31:0] s1);
        base_addr = b; tot_len = t; d0_len = l0; d0_stride = s0; d1_stride = s1;
        req_start = 1'b1;
        tick();
        req_start = 1'b0;
        base_addr = 32'hDEAD_BEEF; tot_len = 16'd7; d0_len = 16'd2;
        d0_stride = 32'h0000_1234; d1_stride = 32'h0000_5678;
    endtask

    // Runs until the cycle after done. mode 0: ready=1; mode 1: ready 1,0,0,1,0,0...
    task automatic collect(input int mode, input int inject_at, output logic [31:0] got[16],
                           output int nb, output int nd, output int done_cyc, output int nhold,
                           output int nvdone, output bit timeout);
        logic [31:0] prev_addr;
        bit          prev_stall;
        nb = 0; nd = 0; done_cyc = -1; nhold = 0; nvdone = 0; timeout = 1'b1;
        prev_stall = 1'b0; prev_addr = '0;
        for (int i = 0; i < 16; i++) got[i] = '0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                nd++;
                if (done_cyc < 0) done_cyc = c;
                if (addr_valid) nvdone++;
            end
            if (prev_stall && (addr !== prev_addr || addr_valid !== 1'b1)) nhold++;
            if (ready_start && nd > 0) begin
                timeout = 1'b0;
                break;
            end
            addr_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            req_start  = (c == inject_at);
            if (addr_valid && addr_ready) begin
                if (nb < 16) got[nb] = addr;
                nb++;
            end
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = addr;
            tick();
        end
        req_start  = 1'b0;
        addr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; req_start = 1'b0; addr_ready = 1'b0;
        base_addr = '0; tot_len = '0; d0_len = '0; d0_stride = '0; d1_stride = '0;
        tick(); tick();
        tests++;
        if ({addr, addr_valid, busy, done, ready_start} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset: addr=%h valid=%b busy=%b done=%b rdy=%b, want 0 0 0 0 1",
                     addr, addr_valid, busy, done, ready_start);
        end
        rst = 1'b0;
        tick();
    endtask

    // Shared checker body is inlined per test, so each test reports under its own name.
    task automatic test_linear();
        logic [31:0] got[16];
        int nb, nd, dc, nh, nv;
        bit to;
        start(32'h100, 16'd4, 16'd0, 32'h10, 32'h0);
        tests++;
        if (addr_valid !== 1'b1 || busy !== 1'b1 || ready_start !== 1'b0) begin
            fails++;
            $display("FAIL linear_start: valid=%b busy=%b rdy=%b, want 1 1 0",
                     addr_valid, busy, ready_start);
        end
        collect(0, -1, got, nb, nd, dc, nh, nv, to);
        tests++;
        if (to || nb != 4 || nd != 1 || dc != 4 || nv != 0) begin
            fails++;
            $display("FAIL linear_counts: to=%0d beats=%0d dones=%0d done_cyc=%0d vd=%0d, want 0 4 1 4 0",
                     to, nb, nd, dc, nv);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== 32'h100 + 32'h10 * i) begin
                fails++;
                $display("FAIL linear_addr[%0d]: got %h want %h", i, got[i], 32'h100 + 32'h10 * i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[16];
        int nb, nd, dc, nh, nv;
        bit to;
        start(32'h100, 16'd4, 16'd0, 32'h10, 32'h0);
        collect(1, -1, got, nb, nd, dc, nh, nv, to);
        tests++;
        if (to || nb != 4 || nd != 1 || nh != 0 || dc != 10) begin
            fails++;
            $display("FAIL bp_counts: to=%0d beats=%0d dones=%0d holdviol=%0d done_cyc=%0d, want 0 4 1 0 10",
                     to, nb, nd, nh, dc);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== 32'h100 + 32'h10 * i) begin
                fails++;
                $display("FAIL bp_addr[%0d]: got %h want %h", i, got[i], 32'h100 + 32'h10 * i);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] got[16];
        int nb, nd, dc, nh, nv;
        bit to;
        start(32'h400, 16'd0, 16'd0, 32'h4, 32'h0);
        collect(0, -1, got, nb, nd, dc, nh, nv, to);
        tests++;
        if (to || nb != 0 || nd != 1 || dc != 0) begin
            fails++;
            $display("FAIL zero_len: to=%0d beats=%0d dones=%0d done_cyc=%0d, want 0 0 1 0",
                     to, nb, nd, dc);
        end
    endtask

    task automatic test_d1();
        logic [31:0] got[16];
        logic [31:0] exp[6];
        int nb, nd, dc, nh, nv;
        bit to;
`ifdef SFM_ADDRGEN_D1_EN
        exp = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48};
`else
        exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
`endif
        start(32'h0, 16'd6, 16'd3, 32'h4, 32'h40);
        collect(0, -1, got, nb, nd, dc, nh, nv, to);
        tests++;
        if (to || nb != 6 || nd != 1) begin
            fails++;
            $display("FAIL d1_counts: to=%0d beats=%0d dones=%0d, want 0 6 1", to, nb, nd);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL d1_addr[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got[16];
        logic [31:0] exp[3];
        int nb, nd, dc, nh, nv;
        bit to;
        exp = '{32'hFFFF_FFF8, 32'h0, 32'h8};
        start(32'hFFFF_FFF8, 16'd3, 16'd0, 32'h8, 32'h0);
        collect(0, -1, got, nb, nd, dc, nh, nv, to);
        tests++;
        if (to || nb != 3 || nd != 1) begin
            fails++;
            $display("FAIL wrap_counts: to=%0d beats=%0d dones=%0d, want 0 3 1", to, nb, nd);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL wrap_addr[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] got[16];
        int nb, nd, dc, nh, nv, ndone;
        bit to;
        start(32'h200, 16'd8, 16'd0, 32'h4, 32'h0);
        addr_ready = 1'b1;
        tests++;
        if (addr !== 32'h200 || addr_valid !== 1'b1) begin
            fails++;
            $display("FAIL clear_beat0: addr=%h valid=%b, want 00000200 1", addr, addr_valid);
        end
        tick();
        tests++;
        if (addr !== 32'h204 || addr_valid !== 1'b1) begin
            fails++;
            $display("FAIL clear_beat1: addr=%h valid=%b, want 00000204 1", addr, addr_valid);
        end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        addr_ready = 1'b0;
        tests++;
        if ({addr, addr_valid, busy, done, ready_start} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL clear_state: addr=%h valid=%b busy=%b done=%b rdy=%b, want 0 0 0 0 1",
                     addr, addr_valid, busy, done, ready_start);
        end
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) ndone++;
            tick();
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL clear_no_done: dones=%0d want 0", ndone);
        end
        start(32'h300, 16'd2, 16'd0, 32'h8, 32'h0);
        collect(0, -1, got, nb, nd, dc, nh, nv, to);
        tests++;
        if (to || nb != 2 || nd != 1 || got[0] !== 32'h300 || got[1] !== 32'h308) begin
            fails++;
            $display("FAIL clear_restart: to=%0d beats=%0d dones=%0d a0=%h a1=%h, want 0 2 1 300 308",
                     to, nb, nd, got[0], got[1]);
        end
    endtask

    task automatic test_start_during_run();
        logic [31:0] got[16];
        int nb, nd, dc, nh, nv;
        bit to;
        start(32'h500, 16'd4, 16'd0, 32'h20, 32'h0);
        collect(0, 2, got, nb, nd, dc, nh, nv, to);
        tests++;
        if (to || nb != 4 || nd != 1 || got[2] !== 32'h540 || got[3] !== 32'h560) begin
            fails++;
            $display("FAIL start_in_run: to=%0d beats=%0d dones=%0d a2=%h a3=%h, want 0 4 1 540 560",
                     to, nb, nd, got[2], got[3]);
        end
        tick();
        tests++;
        if (ready_start !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            fails++;
            $display("FAIL start_in_run_idle: rdy=%b busy=%b valid=%b, want 1 0 0",
                     ready_start, busy, addr_valid);
        end
    endtask

    task automatic test_clear_vs_start();
        base_addr = 32'h700; tot_len = 16'd3; d0_stride = 32'h4;
        req_start = 1'b1;
        clear = 1'b1;
        tick();
        req_start = 1'b0;
        clear = 1'b0;
        tests++;
        if (ready_start !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0 || addr !== 32'h0) begin
            fails++;
            $display("FAIL clear_wins: rdy=%b busy=%b valid=%b addr=%h, want 1 0 0 0",
                     ready_start, busy, addr_valid, addr);
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_backpressure();
        test_zero_len();
        test_d1();
        test_wrap();
        test_clear();
        test_start_during_run();
        test_clear_vs_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
